counter_arbiter: RTL and testbench

Round-robin arbiter that shares one `counter` instance, used as an interval timer, among `Requesters` clients. A winning requester holds an exclusive grant for a programmed number of clock cycles, measured by the shared counter, or until it withdraws its request. The block sits between the requesting logic and the `counter` datapath, and is driven from the Ruby side of the bench like the other samples.

---
 rtl/counter_arbiter_defs.sv | 37 +++
 rtl/counter.sv | 27 ++
 rtl/counter_arbiter.sv | 134 +++++++++++++
 tb/tb_counter_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/counter_arbiter_defs.sv
// counter_arbiter_defs: shared definitions for the counter arbiter.
//   - state_e   : controller state encoding (IDLE=0, RUN=1, DONE=2)
//   - MaxReq    : widest requester vector the helper function handles
//   - rr_pick() : round-robin pick of the first set bit strictly after 'last'
package counter_arbiter_defs;

    localparam int unsigned MaxReq = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Scan n positions starting one past 'last', wrapping modulo n, and return the index of
    // the first requesting bit. Caller guarantees at least one bit of req[n-1:0] is set.
    function automatic logic [2:0] rr_pick(input logic [MaxReq-1:0] req,
                                           input logic [2:0]        last,
                                           input int unsigned       n);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 1; i <= MaxReq; i++) begin
            if (i <= n && !found) begin
                idx = (32'(last) + i) % n;
                if (req[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/counter.sv
// counter: free-running Size-bit up counter with synchronous clear.
//   clock : rising-edge clock
//   reset : synchronous clear, high holds the count at 0
//   count : current count, wraps naturally at 2^Size
module counter #(
    parameter int unsigned Size = 5
) (
    input  logic            clock,
    input  logic            reset,
    output logic [Size-1:0] count
);

    logic [Size-1:0] r_count;

    // The clear is driven from controller state, so it is sampled on the edge rather than
    // used asynchronously.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + Size'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter that lends one shared interval counter to one requester
// at a time. The winner keeps its grant for 'len' cycles (0 means 2^Size) or until it drops
// its request, followed by one dead DONE cycle before the next arbitration.
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   req   : level request vector, one bit per requester
//   len   : hold length, sampled on the grant edge
//   grant : registered one-hot grant (or zero)
//   busy  : grant is non-zero
//   done  : one-cycle pulse in the cycle after a grant ends
//   early : qualifies done; high when the grant ended because req was withdrawn
//   count : shared counter value while running, 0 otherwise
module counter_arbiter
    import counter_arbiter_defs::*;
#(
    parameter int unsigned Size       = 5,
    parameter int unsigned Requesters = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [Requesters-1:0] req,
    input  logic [Size-1:0]       len,
    output logic [Requesters-1:0] grant,
    output logic                  busy,
    output logic                  done,
    output logic                  early,
    output logic [Size-1:0]       count
);

    state_e                r_state;
    logic [Requesters-1:0] r_grant;
    logic [2:0]            r_last;
    logic [Size-1:0]       r_hold;
    logic                  r_done;
    logic                  r_early;

    state_e                w_state_d;
    logic [Requesters-1:0] w_grant_d;
    logic [2:0]            w_last_d;
    logic [Size-1:0]       w_hold_d;
    logic                  w_done_d;
    logic                  w_early_d;

    logic [MaxReq-1:0]     w_req_ext;
    logic [2:0]            w_pick;
    logic [Requesters-1:0] w_pick_onehot;
    logic                  w_cnt_reset;
    logic [Size-1:0]       w_count;
    logic [Size-1:0]       w_last_cnt;
    logic                  w_req_held;

    assign w_req_ext     = MaxReq'(req);
    assign w_pick        = rr_pick(w_req_ext, r_last, Requesters);
    assign w_pick_onehot = Requesters'(1) << w_pick;

    // Wraps to 2^Size-1 when hold is 0, giving the full 2^Size-cycle grant.
    assign w_last_cnt = r_hold - Size'(1);
    assign w_req_held = |(req & r_grant);

    // Counter runs only in RUN; any other state (or block reset) keeps it cleared.
    assign w_cnt_reset = reset || (r_state != StRun);

    counter #(
        .Size (Size)
    ) u_counter (
        .clock (clock),
        .reset (w_cnt_reset),
        .count (w_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_last  <= 3'(Requesters - 1);
            r_hold  <= '0;
            r_done  <= 1'b0;
            r_early <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_grant <= w_grant_d;
            r_last  <= w_last_d;
            r_hold  <= w_hold_d;
            r_done  <= w_done_d;
            r_early <= w_early_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_grant_d = r_grant;
        w_last_d  = r_last;
        w_hold_d  = r_hold;
        w_done_d  = 1'b0;
        w_early_d = 1'b0;
        case (r_state)
            StIdle: begin
                if (|req) begin
                    w_grant_d = w_pick_onehot;
                    w_last_d  = w_pick;
                    w_hold_d  = len;
                    w_state_d = StRun;
                end
            end
            StRun: begin
                // Length expiry is checked first so it wins over a simultaneous withdrawal.
                if (w_count == w_last_cnt) begin
                    w_grant_d = '0;
                    w_done_d  = 1'b1;
                    w_state_d = StDone;
                end else if (!w_req_held) begin
                    w_grant_d = '0;
                    w_done_d  = 1'b1;
                    w_early_d = 1'b1;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
                w_grant_d = '0;
            end
        endcase
    end

    assign grant = r_grant;
    assign busy  = |r_grant;
    assign done  = r_done;
    assign early = r_early;
    assign count = (r_state == StRun) ? w_count : '0;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: directed self-checking bench for counter_arbiter (Size=5, Requesters=4).
// Inputs are driven and outputs sampled on the falling edge, half a cycle from the active edge.
module tb_counter_arbiter;

    logic       clock;
    logic       reset;
    logic [3:0] req;
    logic [4:0] len;
    logic [3:0] grant;
    logic       busy;
    logic       done;
    logic       early;
    logic [4:0] count;

    int n_asserts = 0;
    int n_fail    = 0;

    counter_arbiter #(
        .Size       (5),
        .Requesters (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .req   (req),
        .len   (len),
        .grant (grant),
        .busy  (busy),
        .done  (done),
        .early (early),
        .count (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [3:0] rr_exp [5];

    initial begin
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        reset = 1'b1;
        req   = 4'b0000;
        len   = 5'd0;

        // Reset values
        step();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_early", 32'(early), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        reset = 1'b0;
        step();

        // Round robin from reset: 0,1,2,3,0 with one grant cycle and a two-cycle gap
        req = 4'b1111;
        len = 5'd1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_grant", 32'(grant), 32'(rr_exp[k]));
            check("rr_count", 32'(count), 32'd0);
            step();
            check("rr_gap1_grant", 32'(grant), 32'd0);
            check("rr_gap1_done", 32'(done), 32'd1);
            check("rr_gap1_early", 32'(early), 32'd0);
            if (k == 4) req = 4'b0000;
            step();
            check("rr_gap2_grant", 32'(grant), 32'd0);
            check("rr_gap2_done", 32'(done), 32'd0);
        end

        // Single grant, len=4
        req = 4'b0010;
        len = 5'd4;
        for (int i = 0; i < 4; i++) begin
            step();
            check("single_grant", 32'(grant), 32'b0010);
            check("single_busy", 32'(busy), 32'd1);
            check("single_count", 32'(count), 32'(i));
        end
        step();
        check("single_done", 32'(done), 32'd1);
        check("single_early", 32'(early), 32'd0);
        check("single_grant_off", 32'(grant), 32'd0);
        check("single_count_off", 32'(count), 32'd0);
        req = 4'b0000;
        step();
        check("single_idle_done", 32'(done), 32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);

        // len sampled on grant edge only: 3, then changed to 7 during RUN
        req = 4'b0001;
        len = 5'd3;
        step();
        check("sample_grant", 32'(grant), 32'b0001);
        len = 5'd7;
        step();
        step();
        check("sample_count2", 32'(count), 32'd2);
        check("sample_grant2", 32'(grant), 32'b0001);
        step();
        check("sample_done", 32'(done), 32'd1);
        check("sample_grant_off", 32'(grant), 32'd0);
        req = 4'b0000;
        step();

        // Early release at count 2; other req bits ignored during RUN
        req = 4'b0100;
        len = 5'd10;
        step();
        check("early_grant", 32'(grant), 32'b0100);
        check("early_count0", 32'(count), 32'd0);
        req = 4'b1100;
        step();
        check("early_other_ignored", 32'(grant), 32'b0100);
        check("early_count1", 32'(count), 32'd1);
        step();
        check("early_count2", 32'(count), 32'd2);
        req = 4'b1000;
        step();
        check("early_grant_off", 32'(grant), 32'd0);
        check("early_done", 32'(done), 32'd1);
        check("early_early", 32'(early), 32'd1);
        len = 5'd1;
        step();
        check("turn_idle_grant", 32'(grant), 32'd0);
        check("turn_idle_done", 32'(done), 32'd0);
        check("turn_idle_early", 32'(early), 32'd0);
        step();
        check("turn_grant", 32'(grant), 32'b1000);
        step();
        check("turn_done", 32'(done), 32'd1);
        check("turn_early", 32'(early), 32'd0);
        req = 4'b0000;
        step();

        // Withdrawal on the final count: expiry wins, early=0
        req = 4'b0100;
        len = 5'd10;
        for (int i = 0; i < 10; i++) begin
            step();
            check("sim_grant", 32'(grant), 32'b0100);
            check("sim_count", 32'(count), 32'(i));
            if (i == 9) req = 4'b0000;
        end
        step();
        check("sim_done", 32'(done), 32'd1);
        check("sim_early", 32'(early), 32'd0);
        check("sim_grant_off", 32'(grant), 32'd0);
        step();

        // len=0 means 32 cycles
        req = 4'b0001;
        len = 5'd0;
        for (int i = 0; i < 32; i++) begin
            step();
            check("wrap_grant", 32'(grant), 32'b0001);
            check("wrap_count", 32'(count), 32'(i));
        end
        step();
        check("wrap_done", 32'(done), 32'd1);
        check("wrap_early", 32'(early), 32'd0);
        check("wrap_grant_off", 32'(grant), 32'd0);
        req = 4'b0000;
        step();

        // Asynchronous reset mid-RUN with grant=0001, count=3
        req = 4'b0001;
        len = 5'd10;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_grant", 32'(grant), 32'b0001);
            check("mid_count", 32'(count), 32'(i));
        end
        #2 reset = 1'b1;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        req = 4'b1000;
        step();
        check("mid_rst_hold_grant", 32'(grant), 32'd0);
        reset = 1'b0;
        step();
        check("post_rst_grant", 32'(grant), 32'b1000);
        check("post_rst_count", 32'(count), 32'd0);
        req = 4'b0000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
